// File: rtl/diag_pkg.sv
// Shared types and record geometry for the diagnostic fault collector.
package diag_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDumpRow,
        StDumpSum
    } diag_state_e;

    // One eNVM record holds two S-bit halves.
    function automatic int unsigned rec_width(input int unsigned size);
        return 2 * size;
    endfunction

    // Row records use addresses 0..S-1; the summary record follows them.
    function automatic int unsigned sum_addr(input int unsigned size);
        return size;
    endfunction

endpackage

// File: rtl/diag_fault_collector_if.sv
// Row-beat input, loop-chain control and eNVM write port of the fault collector.
interface diag_fault_collector_if #(
    parameter int unsigned SYSTOLIC_SIZE = 8,
    parameter int unsigned ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE + 1)
);
    logic                         row_valid;
    logic                         row_ready;
    logic [SYSTOLIC_SIZE-1:0]     row_vec;
    logic                         row_last;

    logic                         chain_start_en;
    logic [SYSTOLIC_SIZE-1:0]     chain_col_inputs;
    logic [SYSTOLIC_SIZE-1:0]     chain_single_pe;
    logic [SYSTOLIC_SIZE-1:0]     chain_col_fault;
    logic [SYSTOLIC_SIZE-1:0]     chain_row_fault;

    logic                         envm_wr_valid;
    logic                         envm_wr_ready;
    logic [ADDR_WIDTH-1:0]        envm_wr_addr;
    logic [2*SYSTOLIC_SIZE-1:0]   envm_wr_data;

    modport master (
        input  row_valid, row_vec, row_last,
        output row_ready,
        output chain_start_en, chain_col_inputs,
        input  chain_single_pe, chain_col_fault, chain_row_fault,
        output envm_wr_valid, envm_wr_addr, envm_wr_data,
        input  envm_wr_ready
    );

    modport slave (
        output row_valid, row_vec, row_last,
        input  row_ready,
        input  chain_start_en, chain_col_inputs,
        output chain_single_pe, chain_col_fault, chain_row_fault,
        input  envm_wr_valid, envm_wr_addr, envm_wr_data,
        output envm_wr_ready
    );
endinterface

// File: rtl/diag_rec_counter.sv
// Wrap counter with synchronous clear, enable and a terminal-count flag.
module diag_rec_counter #(
    parameter int unsigned Width  = 3,
    parameter int unsigned MaxVal = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [Width-1:0] count,
    output logic             last
);
    logic [Width-1:0] count_q;

    assign count = count_q;
    assign last  = (count_q == Width'(MaxVal));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= last ? '0 : count_q + 1'b1;
        end
    end
endmodule

// File: rtl/diag_fault_collector.sv
// Loads BIST mismatch patterns into the loop chain, then rotates it out row by row
// into the eNVM followed by a column/row summary record.
module diag_fault_collector
    import diag_pkg::*;
#(
    parameter int unsigned SYSTOLIC_SIZE = 8,
    parameter int unsigned ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   fault_found,
    output logic                   proto_err,
    diag_fault_collector_if.master bus
);
    localparam int unsigned S     = SYSTOLIC_SIZE;
    localparam int unsigned RecW  = rec_width(S);
    localparam int unsigned BeatW = $clog2(S);

    diag_state_e state_q, state_d;

    logic [BeatW-1:0]      beat_cnt;
    logic                  beat_last;
    logic [ADDR_WIDTH-1:0] row_cnt;
    logic                  row_last;

    logic                  start_go;
    logic                  row_hs;
    logic                  wr_acc;
    logic                  pattern_end;

    logic                  done_q;
    logic                  fault_found_q;
    logic                  proto_err_q;
    logic                  snap_pend_q;
    logic [S-1:0]          col_snap_q;
    logic [S-1:0]          row_snap_q;

    assign start_go    = (state_q == StIdle) && start;
    assign row_hs      = (state_q == StLoad) && bus.row_valid;
    assign wr_acc      = bus.envm_wr_valid && bus.envm_wr_ready;
    assign pattern_end = row_hs && beat_last && bus.row_last;

    diag_rec_counter #(
        .Width  (BeatW),
        .MaxVal (S - 1)
    ) u_beat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_go),
        .en    (row_hs),
        .count (beat_cnt),
        .last  (beat_last)
    );

    diag_rec_counter #(
        .Width  (ADDR_WIDTH),
        .MaxVal (S - 1)
    ) u_row_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_go),
        .en    ((state_q == StDumpRow) && wr_acc),
        .count (row_cnt),
        .last  (row_last)
    );

    always_comb begin
        state_d              = state_q;
        bus.row_ready        = 1'b0;
        bus.chain_start_en   = 1'b0;
        bus.chain_col_inputs = '0;
        bus.envm_wr_valid    = 1'b0;
        bus.envm_wr_addr     = row_cnt;
        bus.envm_wr_data     = '0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                bus.row_ready = 1'b1;
                if (bus.row_valid) begin
                    bus.chain_start_en   = 1'b1;
                    bus.chain_col_inputs = bus.row_vec;
                    if (beat_last && bus.row_last) state_d = StDumpRow;
                end
            end
            StDumpRow: begin
                bus.envm_wr_valid = 1'b1;
                bus.envm_wr_data  = {{S{1'b0}}, bus.chain_single_pe};
                // Accepting a row rotates the next one to the top of the chain.
                if (bus.envm_wr_ready) begin
                    bus.chain_start_en = 1'b1;
                    if (row_last) state_d = StDumpSum;
                end
            end
            StDumpSum: begin
                bus.envm_wr_valid = 1'b1;
                bus.envm_wr_addr  = ADDR_WIDTH'(sum_addr(S));
                bus.envm_wr_data  = {col_snap_q, row_snap_q};
                if (bus.envm_wr_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // The chain takes the final pattern on the same edge we leave LOAD, so its
    // fault flags are only valid during the first DUMP_ROW cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_pend_q <= 1'b0;
            col_snap_q  <= '0;
            row_snap_q  <= '0;
        end else begin
            snap_pend_q <= pattern_end;
            if (snap_pend_q) begin
                col_snap_q <= bus.chain_col_fault;
                row_snap_q <= bus.chain_row_fault;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q        <= 1'b0;
            fault_found_q <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            done_q <= (state_q == StDumpSum) && wr_acc;
            if (start_go) begin
                fault_found_q <= 1'b0;
                proto_err_q   <= 1'b0;
            end else begin
                if (wr_acc && (bus.envm_wr_data != RecW'(0))) fault_found_q <= 1'b1;
                if (row_hs && bus.row_last && !beat_last) proto_err_q <= 1'b1;
            end
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign fault_found = fault_found_q;
    assign proto_err   = proto_err_q;
endmodule

// File: tb/tb_diag_fault_collector.sv
// Randomized scoreboard bench for diag_fault_collector with a behavioural loop-chain model.
module tb_diag_fault_collector;
    localparam int unsigned S  = 8;
    localparam int unsigned AW = $clog2(S + 1);
    localparam int unsigned RW = 2 * S;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, fault_found, proto_err;

    diag_fault_collector_if #(.SYSTOLIC_SIZE(S), .ADDR_WIDTH(AW)) bus ();

    diag_fault_collector #(
        .SYSTOLIC_SIZE (S),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .fault_found (fault_found),
        .proto_err   (proto_err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    rec_t exp_q[$];
    rec_t exp_rec;
    rec_t prev_rec;
    logic [S-1:0] acc [S];
    logic [S-1:0] stim_q[$];
    int ready_mode = 0;
    int wait_cnt = 0;
    int load_en_cnt = 0;
    int dump_en_cnt = 0;
    bit prev_stall = 0;
    bit sum_prev = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    // Loop chain: each shift drops the top row and appends it, ORed with the input, at the bottom.
    logic [S-1:0] chain_mem [S];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < S; i++) chain_mem[i] <= '0;
        end else if (bus.chain_start_en) begin
            for (int i = 0; i < S - 1; i++) chain_mem[i] <= chain_mem[i + 1];
            chain_mem[S-1] <= chain_mem[0] | bus.chain_col_inputs;
        end
    end

    always_comb begin
        bus.chain_single_pe = chain_mem[0];
        bus.chain_col_fault = '0;
        bus.chain_row_fault = '0;
        for (int i = 0; i < S; i++) begin
            bus.chain_col_fault    = bus.chain_col_fault | chain_mem[i];
            bus.chain_row_fault[i] = |chain_mem[i];
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            wait_cnt   = 0;
            prev_stall = 0;
            sum_prev   = 0;
        end else begin
            if (sum_prev) check("done_after_sum", done, 1);
            sum_prev = bus.envm_wr_valid && bus.envm_wr_ready && (bus.envm_wr_addr == AW'(S));
            if (bus.chain_start_en) begin
                if (bus.row_ready) load_en_cnt++;
                else if (bus.envm_wr_valid) dump_en_cnt++;
            end
            if (bus.envm_wr_valid) begin
                if (prev_stall) begin
                    check("stable_addr", bus.envm_wr_addr, prev_rec.addr);
                    check("stable_data", bus.envm_wr_data, prev_rec.data);
                end
                if (bus.envm_wr_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write actual addr %0h data %0h required none",
                                 bus.envm_wr_addr, bus.envm_wr_data);
                    end else begin
                        exp_rec = exp_q.pop_front();
                        check("wr_addr", bus.envm_wr_addr, exp_rec.addr);
                        check("wr_data", bus.envm_wr_data, exp_rec.data);
                    end
                    wait_cnt   = 0;
                    prev_stall = 0;
                end else begin
                    check("no_shift_in_stall", bus.chain_start_en, 0);
                    wait_cnt++;
                    prev_stall    = 1;
                    prev_rec.addr = bus.envm_wr_addr;
                    prev_rec.data = bus.envm_wr_data;
                end
            end else begin
                prev_stall = 0;
            end
        end
    end

    initial begin
        bus.envm_wr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.envm_wr_ready = 1'b1;
                1:       bus.envm_wr_ready = (wait_cnt >= 5);
                default: bus.envm_wr_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < S; i++) acc[i] = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic push_pattern(input int hot_row, input logic [S-1:0] val);
        for (int r = 0; r < S; r++) stim_q.push_back((r == hot_row) ? val : '0);
    endtask

    task automatic push_random(input int npat);
        for (int i = 0; i < npat * S; i++)
            stim_q.push_back(($urandom_range(0, 3) == 0) ? S'($urandom) : '0);
    endtask

    task automatic collect(input int bad_beat, input int abort_row);
        int npat;
        bit exp_ff;
        bit hs;
        bit got;
        rec_t r;
        logic [S-1:0] colf;
        logic [S-1:0] rowf;
        npat   = stim_q.size() / S;
        exp_ff = 0;
        colf   = '0;
        rowf   = '0;
        for (int i = 0; i < stim_q.size(); i++) acc[i % S] = acc[i % S] | stim_q[i];
        for (int i = 0; i < S; i++) begin
            r.addr = AW'(i);
            r.data = {{S{1'b0}}, acc[i]};
            exp_q.push_back(r);
            colf    = colf | acc[i];
            rowf[i] = (acc[i] != 0);
            if (acc[i] != 0) exp_ff = 1;
        end
        r.addr = AW'(S);
        r.data = {colf, rowf};
        exp_q.push_back(r);

        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        load_en_cnt = 0;
        dump_en_cnt = 0;

        for (int p = 0; p < npat; p++) begin
            for (int b = 0; b < S; b++) begin
                bus.row_valid = 1'b0;
                if ($urandom_range(0, 3) == 0) step();
                bus.row_valid = 1'b1;
                bus.row_vec   = stim_q[p * S + b];
                bus.row_last  = ((b == S - 1) && (p == npat - 1)) || ((p == 0) && (b == bad_beat));
                hs = 0;
                for (int t = 0; t < 50 && !hs; t++) begin
                    @(negedge clk);
                    hs = bus.row_ready;
                    step();
                end
                if (!hs) begin
                    checks++;
                    errors++;
                    $display("FAIL row_handshake_timeout actual no ready required ready");
                end
            end
        end
        bus.row_valid = 1'b0;
        bus.row_last  = 1'b0;
        bus.row_vec   = '0;
        stim_q.delete();

        if (abort_row >= 0) begin
            got = 0;
            for (int t = 0; t < 400 && !got; t++) begin
                @(negedge clk);
                if (bus.envm_wr_valid && (bus.envm_wr_addr == AW'(abort_row))) got = 1;
            end
            check("abort_row_reached", got, 1);
            rst_n = 1'b0;
            #1;
            clear_model();
            check("rst_busy", busy, 0);
            check("rst_wr_valid", bus.envm_wr_valid, 0);
            check("rst_wr_addr", bus.envm_wr_addr, 0);
            check("rst_wr_data", bus.envm_wr_data, 0);
            check("rst_done", done, 0);
            check("rst_flags", {fault_found, proto_err}, 0);
            check("rst_shift", bus.chain_start_en, 0);
            step();
            step();
            rst_n = 1'b1;
            step();
        end else begin
            got = 0;
            for (int t = 0; t < 400 && !got; t++) begin
                @(negedge clk);
                if (done) got = 1;
            end
            check("done_seen", got, 1);
            if (got) begin
                check("busy_at_done", busy, 0);
                check("fault_found", fault_found, exp_ff);
                check("proto_err", proto_err, (bad_beat >= 0) && (bad_beat < S - 1));
                check("queue_drained", exp_q.size(), 0);
                @(negedge clk);
                check("done_one_cycle", done, 0);
            end
        end
    endtask

    initial begin
        bus.row_valid = 1'b0;
        bus.row_vec   = '0;
        bus.row_last  = 1'b0;
        clear_model();
        do_reset();

        // Idle: row beats are refused and nothing reaches the chain or the eNVM.
        bus.row_valid = 1'b1;
        bus.row_vec   = 8'hA5;
        #1;
        check("idle_row_ready", bus.row_ready, 0);
        check("idle_shift", bus.chain_start_en, 0);
        check("idle_col_inputs", bus.chain_col_inputs, 0);
        check("idle_wr_valid", bus.envm_wr_valid, 0);
        check("idle_wr_addr", bus.envm_wr_addr, 0);
        check("idle_wr_data", bus.envm_wr_data, 0);
        check("idle_status", {busy, done, fault_found, proto_err}, 0);
        bus.row_valid = 1'b0;
        bus.row_vec   = '0;
        step();

        ready_mode = 0;
        push_pattern(2, 8'h10);
        collect(-1, -1);

        do_reset();
        push_pattern(0, 8'h01);
        push_pattern(0, 8'h80);
        collect(-1, -1);
        check("load_shifts", load_en_cnt, 16);
        check("dump_shifts", dump_en_cnt, 8);

        do_reset();
        ready_mode = 1;
        push_random(1);
        collect(-1, -1);
        check("stall_dump_shifts", dump_en_cnt, 8);
        ready_mode = 0;

        push_random(1);
        collect(3, -1);

        push_random(2);
        collect(-1, 4);
        push_random(1);
        collect(-1, -1);

        do_reset();
        push_pattern(0, 8'h00);
        push_pattern(0, 8'h00);
        collect(-1, -1);

        ready_mode = 2;
        for (int n = 0; n < 6; n++) begin
            push_random(int'($urandom_range(1, 3)));
            collect(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, S - 2)) : -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/diag_fault_collector.md
Name: diag_fault_collector

Overview:
- Controls the diagnostic loop chain and reads its results.
- Loads per-row PE mismatch vectors from the BIST comparator into the chain as one or more test patterns. The chain ORs each pattern into the previous ones.
- After the last pattern, rotates the chain row by row and writes each row's fault vector, then a column/row summary word, into the eNVM through a valid/ready write port.
- Sits between the BIST compare stage, the loop chain and the eNVM write interface. It generates all eNVM addresses, because the chain has no address counter.

Parameters:
- SYSTOLIC_SIZE, 8, array dimension S (rows = columns = chain depth); minimum 3.
- ADDR_WIDTH, $clog2(SYSTOLIC_SIZE+1), eNVM record address width; must hold S.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a collection; ignored unless IDLE.
- row_valid  in  1  mismatch row beat valid.
- row_ready  out  1  collector accepts a row beat.
- row_vec  in  S  per-PE mismatch flags of the current row, row 0 first.
- row_last  in  1  marks the final pattern; sampled only on beat S-1.
- chain_start_en  out  1  chain shift enable (combinational).
- chain_col_inputs  out  S  chain input vector (combinational).
- chain_single_pe  in  S  chain top-stage row vector.
- chain_col_fault  in  S  chain column fault flags.
- chain_row_fault  in  S  chain row fault flags.
- envm_wr_valid  out  1  write request.
- envm_wr_ready  in  1  eNVM accepts the write.
- envm_wr_addr  out  ADDR_WIDTH  record address.
- envm_wr_data  out  2S  record data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the summary write is accepted.
- fault_found  out  1  sticky; some written record was nonzero.
- proto_err  out  1  sticky; row_last was seen on a beat other than S-1.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, all counters 0.
- FSM states: IDLE, LOAD, DUMP_ROW, DUMP_SUM.
- IDLE -> LOAD on start. In the same transition clear fault_found and proto_err, and set beat and row counters to 0.
- LOAD:
  - row_ready = 1.
  - On each handshake (row_valid & row_ready): chain_col_inputs = row_vec and chain_start_en = 1. Outside a handshake both are 0.
  - The beat counter wraps S-1 -> 0.
  - row_last on beat S-1 -> go to DUMP_ROW. In the same cycle snapshot chain_col_fault/chain_row_fault on the following clock, i.e. the first DUMP_ROW cycle, into summary registers.
  - row_last on beat S-1 = 0 -> next pattern; stay in LOAD.
  - row_last = 1 on any other beat sets proto_err and is otherwise ignored.
- DUMP_ROW:
  - envm_wr_valid = 1, envm_wr_addr = row counter r, envm_wr_data = {S'b0, chain_single_pe}.
  - Address and data stay stable until envm_wr_ready.
  - On the accept cycle: chain_start_en = 1, which rotates the next row to the top, and r increments.
  - After r = S-1 is accepted -> DUMP_SUM. After S rotations the chain content is back in its original alignment and is not modified.
- DUMP_SUM:
  - envm_wr_valid = 1, addr = S, data = {col_fault_snap, row_fault_snap}.
  - On accept: done pulses for 1 cycle, then return to IDLE.
  - chain_start_en = 0 in this state.
- chain_col_inputs is 0 outside LOAD handshakes. The chain only ever sees data or zero, so patterns OR-accumulate across collections until rst_n.
- fault_found is set on acceptance of any record with nonzero data and held until the next start.
- envm_wr_valid, once asserted, is never dropped before ready.
- start while busy: ignored.
- row_valid outside LOAD: ignored, row_ready = 0.
- Zero-latency path: row_ready, chain_start_en and chain_col_inputs are combinational from the state and the handshake inputs. envm outputs are driven from registers and the state.
- rst_n mid-operation: the FSM returns to IDLE immediately and any pending write is abandoned. The chain resets on the same rst_n.

Decomposition:
- Package diag_pkg holds:
  - the state enum (IDLE, LOAD, DUMP_ROW, DUMP_SUM);
  - the record-width constant 2*SYSTOLIC_SIZE;
  - the summary-address constant SYSTOLIC_SIZE.
- One natural sub-module, diag_rec_counter: a wrap counter with enable and terminal flag, used for both the beat counter and the row counter.

Test Plan:
- S=8, start, one pattern, only row 2 = 8'h10, row_last on beat 7, envm_wr_ready tied 1 -> writes at addr 0..7 with data 0 except addr 2 = 16'h0010; addr 8 written; done 1 cycle after the addr-8 accept; fault_found = 1.
- Two patterns, row 0 = 8'h01 then row 0 = 8'h80 -> addr 0 data 16'h0081 (OR accumulation); chain_start_en asserted 16 times in LOAD and 8 times in dump.
- envm_wr_ready held low for 5 cycles on each record -> addr/data stable, no extra chain_start_en, record order unchanged.
- row_last asserted on beat 3 -> proto_err = 1, LOAD continues, dump starts only after beat 7 with last.
- rst_n asserted during DUMP_ROW at r=4 -> all outputs 0 next cycle, busy 0; a new start runs a full clean collection.
- All-zero patterns -> 9 records all zero, fault_found = 0, done pulses.
